// File: rtl/mprj_enable_sequencer.sv
// Staged enable sequencer for the management/user-project boundary: groups rise in
// order with a settle gap, fall in reverse, and collapse at once on power loss.
module mprj_enable_sequencer #(
  parameter int NGROUPS = 4,
  parameter int SETTLE  = 8,
  parameter int CW      = $clog2(SETTLE + 1)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               en_req,
  input  logic               pwr_good,
  input  logic [NGROUPS-1:0] hi_i,
  output logic [NGROUPS-1:0] grp_en,
  output logic               ready,
  output logic               busy,
  output logic               fault,
  output logic [2:0]         dbg_state
);

  localparam int IW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NGROUPS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_WAIT_PG   = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_ON        = 3'd3,
    S_RAMP_DOWN = 3'd4
  } state_t;

  state_t             r_state, w_state_d;
  logic [NGROUPS-1:0] r_en_q, w_en_d;
  logic [IW-1:0]      r_idx, w_idx_d;
  logic [CW-1:0]      r_cnt, w_cnt_d;
  logic               r_ready, w_ready_d;
  logic               r_fault, w_fault_d;
  logic               r_busy;
  logic               w_busy_d;
  logic               w_pwr_lost;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_OFF;
      r_en_q  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_fault <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_en_q  <= w_en_d;
      r_idx   <= w_idx_d;
      r_cnt   <= w_cnt_d;
      r_ready <= w_ready_d;
      r_fault <= w_fault_d;
      r_busy  <= w_busy_d;
    end
  end

  // Power loss outranks every other transition while any enable may be active.
  assign w_pwr_lost = !pwr_good &&
                      ((r_state == S_RAMP_UP) || (r_state == S_ON) || (r_state == S_RAMP_DOWN));

  always_comb begin
    w_state_d = r_state;
    w_en_d    = r_en_q;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt;
    w_ready_d = r_ready;
    w_fault_d = r_fault;
    if (w_pwr_lost) begin
      w_state_d = S_OFF;
      w_en_d    = '0;
      w_idx_d   = '0;
      w_cnt_d   = '0;
      w_ready_d = 1'b0;
      w_fault_d = 1'b1;
    end else begin
      case (r_state)
        S_OFF: begin
          if (!en_req)
            w_fault_d = 1'b0;
          else if (!r_fault)
            w_state_d = S_WAIT_PG;
        end
        S_WAIT_PG: begin
          if (!en_req) begin
            w_state_d = S_OFF;
          end else if (pwr_good) begin
            w_state_d = S_RAMP_UP;
            w_en_d[0] = 1'b1;
            w_idx_d   = '0;
            w_cnt_d   = '0;
          end
        end
        S_RAMP_UP, S_ON: begin
          // Dropping the request starts the descent from the highest enabled group.
          if (!en_req) begin
            w_state_d      = S_RAMP_DOWN;
            w_en_d[r_idx]  = 1'b0;
            w_ready_d      = 1'b0;
            w_cnt_d        = '0;
          end else if (r_state == S_RAMP_UP) begin
            if (r_cnt == CNT_LAST) begin
              if (r_idx < LAST_IDX) begin
                w_en_d[r_idx + 1'b1] = 1'b1;
                w_idx_d              = r_idx + 1'b1;
                w_cnt_d              = '0;
              end else begin
                w_state_d = S_ON;
                w_ready_d = 1'b1;
              end
            end else begin
              w_cnt_d = r_cnt + CW'(1);
            end
          end
        end
        S_RAMP_DOWN: begin
          // en_req is deliberately ignored until OFF is reached.
          if (r_cnt == CNT_LAST) begin
            w_cnt_d = '0;
            if (r_idx != '0) begin
              w_en_d[r_idx - 1'b1] = 1'b0;
              w_idx_d              = r_idx - 1'b1;
            end else begin
              w_state_d = S_OFF;
            end
          end else begin
            w_cnt_d = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_d = S_OFF;
          w_en_d    = '0;
          w_idx_d   = '0;
          w_cnt_d   = '0;
          w_ready_d = 1'b0;
        end
      endcase
    end
    w_busy_d = (w_state_d == S_WAIT_PG) || (w_state_d == S_RAMP_UP) ||
               (w_state_d == S_RAMP_DOWN);
  end

  assign grp_en    = r_en_q & hi_i;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign fault     = r_fault;
  assign dbg_state = r_state;

endmodule

// File: doc/mprj_enable_sequencer.md
# mprj_enable_sequencer

Sequences the management-to-user-project interface enables in staged groups. Enables rise in order with a programmable settle gap and fall in reverse order, which limits inrush and glitching on signals crossing into the user area. Each group enable is ANDed with its tie-high source bit from the logic-high cell array, so a group whose tie-high is absent can never assert. The block sits between the housekeeping enable control and the mgmt-protect gating logic.

## Interface
Parameters:
- NGROUPS, 4, number of enable groups (≥1)
- SETTLE, 8, cycles between successive group transitions (≥1)
- CW, $clog2(SETTLE+1), settle counter width

Ports:
- wb_clk_i  input  1  clock
- wb_rst_i  input  1  reset; synchronous, active-high
- en_req  input  1  level request: 1 = user interface enabled, 0 = disabled
- pwr_good  input  1  user-domain power good; must be high to ramp up or stay up
- hi_i  input  NGROUPS  tie-high source bits, one per group
- grp_en  output  NGROUPS  group enables = en_q & hi_i
- ready  output  1  all groups enabled and the final settle period has elapsed
- busy  output  1  state is WAIT_PG, RAMP_UP or RAMP_DOWN
- fault  output  1  sticky flag: power was lost while enables were active

## Operation
- Internal registers: state, en_q[NGROUPS-1:0], idx (group index), cnt[CW-1:0], fault.
- Reset: state=OFF; en_q=0; idx=0; cnt=0; fault=0. Hence grp_en=0, ready=0, busy=0.
- OFF:
  - If en_req=1 and fault=0, go to WAIT_PG.
  - If en_req=0, clear fault.
- WAIT_PG:
  - If en_req=0, go to OFF.
  - Else if pwr_good=1, go to RAMP_UP and set en_q[0], idx=0, cnt=0.
  - pwr_good=0 here only waits; it does not raise fault.
- RAMP_UP: cnt increments each cycle. When cnt reaches SETTLE-1:
  - If idx<NGROUPS-1: set en_q[idx+1], idx++, cnt=0.
  - Else: go to ON with ready=1.
- ON: hold en_q all ones with ready=1.
- RAMP_UP or ON with en_req=0:
  - Go to RAMP_DOWN, clear en_q[idx] and ready on the same edge, cnt=0.
- RAMP_DOWN: when cnt reaches SETTLE-1:
  - If idx>0: clear en_q[idx-1], idx--, cnt=0.
  - Else: go to OFF.
  - en_req returning high is ignored until OFF is reached; the re-ramp then starts from OFF.
- Power loss: pwr_good=0 in RAMP_UP, ON or RAMP_DOWN has priority over all other transitions. Next edge: en_q=0, ready=0, fault=1, state=OFF.
- hi_i bit k low: grp_en[k] stays 0. Sequencing timing is unchanged.
- Reset mid-operation: on the next edge all registers take their reset values. The reset response is immediate; there is no staged ramp-down.

## Timing
- All outputs are registered except grp_en, which is en_q ANDed combinationally with hi_i.
- Ramp up, with NGROUPS=4, SETTLE=8, pwr_good=1, en_req first sampled high at edge 1:
  - busy=1 from edge 1.
  - grp_en[0] rises at edge 2, [1] at 10, [2] at 18, [3] at 26.
  - ready=1 and busy=0 at edge 34.
  - General form: grp_en[k] rises at edge 2+k·SETTLE; ready rises at edge 2+NGROUPS·SETTLE.
- Ramp down, en_req first sampled low at edge t while in ON:
  - ready and grp_en[3] fall at t.
  - grp_en[2] falls at t+8, [1] at t+16, [0] at t+24.
  - OFF is reached and busy=0 at t+32.
- Abort during ramp up: the highest enabled group falls at the sampling edge, then one group per SETTLE cycles.
- Power loss: all enables clear one edge after pwr_good is sampled low.

## Test plan
- Full ramp up: reset, then en_req=1 with pwr_good=1 → grp_en 0001@2, 0011@10, 0111@18, 1111@26; ready@34; busy high from edge 1 to 33.
- Full ramp down: from ON, drop en_req at t → grp_en 0111@t, 0011@t+8, 0001@t+16, 0000@t+24; busy=0@t+32; re-asserting en_req at t+5 has no effect before OFF.
- Abort mid-ramp: drop en_req at edge 12 (grp_en=0011) → 0001@12, 0000@20, OFF@28.
- Power fault: in ON, pwr_good=0 for 1 cycle → grp_en=0000 and fault=1 next edge; en_req held high does not restart; en_req=0 clears fault; en_req=1 then ramps normally.
- Tie-high gating: hi_i=1011 → grp_en 1011 in ON; ready timing identical to the full ramp-up case.
- Power wait and reset: en_req=1 with pwr_good=0 → WAIT_PG, grp_en=0, fault=0; then pwr_good=1 → grp_en[0] one edge later; wb_rst_i=1 at edge 20 → all outputs 0 at edge 21.
